// File: rtl/onchip_arb_pkg.sv
// Purpose: shared defaults and master id type for the on-chip RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package onchip_arb_pkg;

  localparam int          DEF_ADDR_W   = 14;
  localparam int          DEF_DATA_W   = 32;
  localparam int          DEF_BE_W     = DEF_DATA_W / 8;
  localparam int          DEF_DEPTH    = 10000;
  localparam logic [31:0] DEF_OOR_DATA = 32'hDEADBEEF;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arbiter2.sv
// Purpose: two-request round-robin grant; optional bus lock when ONCHIP_ARB_LOCK_EN is defined.
// Latency: grant is combinational from req; last_grant and lock state update on granted edges.
// Backpressure: blocked[i] marks a master shut out by the other master's held lock.
module rr_arbiter2
  import onchip_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
`ifdef ONCHIP_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  output logic       grant_vld,
  output master_id_t grant_id,
  output logic [1:0] blocked
);

  master_id_t last_grant;
  logic [1:0] eff_req;

`ifdef ONCHIP_ARB_LOCK_EN
  logic       lock_vld;
  master_id_t lock_owner;
  logic       owner_lock;
  logic       grant_lock;

  assign owner_lock = (lock_owner == M1) ? lock[1] : lock[0];
  assign grant_lock = (grant_id == M1) ? lock[1] : lock[0];
  // Only the registered lock state blocks, so the release lands the cycle after the owner drops lock.
  assign blocked    = !lock_vld ? 2'b00 : ((lock_owner == M0) ? 2'b10 : 2'b01);

  // Hold the lock while the owner keeps lock high; otherwise capture a new locked grant or release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld   <= 1'b0;
      lock_owner <= M0;
    end else if (!(lock_vld && owner_lock)) begin
      if (grant_vld && grant_lock) begin
        lock_vld   <= 1'b1;
        lock_owner <= grant_id;
      end else begin
        lock_vld   <= 1'b0;
      end
    end
  end
`else
  assign blocked = 2'b00;
`endif

  assign eff_req = req & ~blocked;

  // Single requester wins outright; on contention the master not granted last time wins.
  always_comb begin
    grant_vld = |eff_req;
    grant_id  = M0;
    case (eff_req)
      2'b01:   grant_id = M0;
      2'b10:   grant_id = M1;
      2'b11:   grant_id = (last_grant == M0) ? M1 : M0;
      default: grant_id = M0;
    endcase
  end

  // Remember the winner of every granted cycle; reset favours m0 at the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= M1;
    end else if (grant_vld) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Purpose: shares a single-port RAM between two Avalon-MM masters, with OOR protection (lock via ONCHIP_ARB_LOCK_EN).
// Latency: writes zero-latency; reads return readdatavalid exactly one cycle after accept.
// Backpressure: the losing requester (or a lock-blocked master) sees waitrequest=1; idle masters see 0.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                BE_W     = DEF_BE_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [DATA_W-1:0] OOR_DATA = DEF_OOR_DATA
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef ONCHIP_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              err_oor,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [1:0]        raw_req;
  logic [1:0]        req;
  logic [1:0]        blocked;
  logic              grant_vld;
  master_id_t        grant_id;
  logic              sel_write;
  logic              sel_oor;
  logic              rd_pending;
  master_id_t        rd_owner;
  logic              rd_oor;
  logic [DATA_W-1:0] ret_data;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  assign raw_req = {m1_read | m1_write, m0_read | m0_write};
  // Nothing is granted while reset is held, so both masters stall and the RAM stays deselected.
  assign req     = raw_req & {2{reset_n}};

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (reset_n),
    .req       (req),
`ifdef ONCHIP_ARB_LOCK_EN
    .lock      ({m1_lock, m0_lock}),
`endif
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .blocked   (blocked)
  );

  assign m0_waitrequest = !reset_n || blocked[0] || (raw_req[0] && !(grant_vld && grant_id == M0));
  assign m1_waitrequest = !reset_n || blocked[1] || (raw_req[1] && !(grant_vld && grant_id == M1));

  // Read+write together counts as a write; the read half is never returned.
  assign sel_write      = (grant_id == M1) ? m1_write      : m0_write;
  assign mem_address    = (grant_id == M1) ? m1_address    : m0_address;
  assign mem_byteenable = (grant_id == M1) ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = (grant_id == M1) ? m1_writedata  : m0_writedata;
  assign sel_oor        = {1'b0, mem_address} >= DEPTH_LIM;

  // Out-of-range accesses are still accepted but never reach the RAM.
  assign mem_chipselect = grant_vld && !sel_oor;
  assign mem_write      = mem_chipselect && sel_write;

  // Tag each accepted read so the next cycle's RAM data is steered to its owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
      rd_owner   <= M0;
      rd_oor     <= 1'b0;
    end else begin
      rd_pending <= grant_vld && !sel_write;
      rd_owner   <= grant_id;
      rd_oor     <= sel_oor;
    end
  end

  assign ret_data         = rd_oor ? OOR_DATA : mem_readdata;
  assign m0_readdatavalid = rd_pending && (rd_owner == M0);
  assign m1_readdatavalid = rd_pending && (rd_owner == M1);
  assign m0_readdata      = m0_readdatavalid ? ret_data : hold0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : hold1;

  // Keep each master's last returned word so readdata is stable between returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (m0_readdatavalid) hold0 <= ret_data;
      if (m1_readdatavalid) hold1 <= ret_data;
    end
  end

  // Sticky error: a new out-of-range accept beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_oor <= 1'b0;
    end else if (grant_vld && sel_oor) begin
      err_oor <= 1'b1;
    end else if (err_clr) begin
      err_oor <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Purpose: checks onchip_mem_arbiter against a transaction-level model with a 1-cycle RAM behind it.
// Latency: model predicts each cycle's outputs; read data expected one cycle after accept.
// Backpressure: masters hold a request stable until the model says it was accepted.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic        err_oor;
  logic        err_clr = 1'b0;
`ifdef ONCHIP_ARB_LOCK_EN
  logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
`ifdef ONCHIP_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .err_oor(err_oor), .err_clr(err_clr)
  );

  // RAM slave: 10000 words, byte-lane writes, registered read data.
  logic [31:0] ram [10000];
  logic [31:0] ram_q;
  bit          ram_init = 1'b0;
  assign mem_readdata = ram_q;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 10000; i++) ram[i] = i * 32'h9E3779B1;
      ram_init = 1'b1;
    end
    if (mem_chipselect && mem_address < 14'd10000) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [10000];
  int          last_g;
  bit          pend_v;
  int          pend_o;
  logic [31:0] pend_d;
  logic [31:0] hold [2];
  bit          err_m;
  bit          lk_v;
  int          lk_o;
  bit          acc0, acc1;
  logic        smp_w0, smp_w1, smp_rdv0, smp_rdv1, smp_cs, smp_err;
  logic [31:0] smp_rd0, smp_rd1;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  // One clock: compare outputs at the falling edge, then advance the model to the rising edge.
  task automatic tick();
    bit r0, r1, b0, b1, wr, oor, cs, e_rdv0, e_rdv1, glock, olock;
    int g;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    b0 = lk_v && lk_o == 1;
    b1 = lk_v && lk_o == 0;
    if (r0 && !b0 && r1 && !b1) g = (last_g == 0) ? 1 : 0;
    else if (r0 && !b0)         g = 0;
    else if (r1 && !b1)         g = 1;
    else                        g = -1;
    a   = (g == 1) ? m1_address    : m0_address;
    be  = (g == 1) ? m1_byteenable : m0_byteenable;
    wd  = (g == 1) ? m1_writedata  : m0_writedata;
    wr  = (g == 1) ? m1_write      : m0_write;
    oor = (a >= 14'd10000);
    cs  = (g >= 0) && !oor;
    e_rdv0 = pend_v && pend_o == 0;
    e_rdv1 = pend_v && pend_o == 1;
    smp_w0 = m0_waitrequest;  smp_w1 = m1_waitrequest;
    smp_rdv0 = m0_readdatavalid; smp_rdv1 = m1_readdatavalid;
    smp_rd0 = m0_readdata; smp_rd1 = m1_readdata;
    smp_cs = mem_chipselect; smp_err = err_oor;
    check_eq("wait0", m0_waitrequest, b0 || (r0 && g != 0));
    check_eq("wait1", m1_waitrequest, b1 || (r1 && g != 1));
    check_eq("mem_cs", mem_chipselect, cs);
    check_eq("mem_wr", mem_write, cs && wr);
    if (cs) begin
      check_eq("mem_addr", mem_address, a);
      check_eq("mem_be", mem_byteenable, be);
      if (wr) check_eq("mem_wdata", mem_writedata, wd);
    end
    check_eq("rdv0", m0_readdatavalid, e_rdv0);
    check_eq("rdv1", m1_readdatavalid, e_rdv1);
    check_eq("rdata0", m0_readdata, e_rdv0 ? pend_d : hold[0]);
    check_eq("rdata1", m1_readdata, e_rdv1 ? pend_d : hold[1]);
    check_eq("err_oor", err_oor, err_m);
    if (e_rdv0) hold[0] = pend_d;
    if (e_rdv1) hold[1] = pend_d;
    pend_v = 1'b0;
    acc0 = (g == 0);
    acc1 = (g == 1);
    if (g >= 0) begin
      last_g = g;
      if (!wr) begin
        pend_v = 1'b1;
        pend_o = g;
        pend_d = oor ? 32'hDEADBEEF : ref_mem[a];
      end else if (!oor) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (g >= 0 && oor) err_m = 1'b1;
    else if (err_clr)  err_m = 1'b0;
    glock = 1'b0;
    olock = 1'b0;
`ifdef ONCHIP_ARB_LOCK_EN
    glock = (g == 0) ? m0_lock : ((g == 1) ? m1_lock : 1'b0);
    olock = (lk_o == 0) ? m0_lock : m1_lock;
`endif
    if (!(lk_v && olock)) begin
      if (g >= 0 && glock) begin lk_v = 1'b1; lk_o = g; end
      else lk_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_wait0", m0_waitrequest, 1'b1);
    check_eq("rst_wait1", m1_waitrequest, 1'b1);
    check_eq("rst_rdv0", m0_readdatavalid, 1'b0);
    check_eq("rst_rdv1", m1_readdatavalid, 1'b0);
    check_eq("rst_rdata0", m0_readdata, 32'h0);
    check_eq("rst_rdata1", m1_readdata, 32'h0);
    check_eq("rst_err", err_oor, 1'b0);
    check_eq("rst_cs", mem_chipselect, 1'b0);
    check_eq("rst_mwr", mem_write, 1'b0);
    last_g = 1; pend_v = 1'b0; hold[0] = '0; hold[1] = '0;
    err_m = 1'b0; lk_v = 1'b0; lk_o = 0; acc0 = 1'b0; acc1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic issue(input int m, input bit rd, input bit wr, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    bit got;
    got = 1'b0;
    drive(m, rd, wr, a, be, d);
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = (m == 0) ? acc0 : acc1;
    end
    check_eq("accept", got, 1'b1);
    drive(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rand_req(input int m);
    int p, q;
    bit rd, wr;
    logic [13:0] a;
    p = $urandom_range(0, 99);
    rd = (p >= 30 && p < 65) || p >= 95;
    wr = p >= 65;
    q = $urandom_range(0, 9);
    if (q < 8)       a = 14'($urandom_range(0, 31));
    else if (q == 8) a = 14'($urandom_range(9990, 9999));
    else             a = 14'($urandom_range(10000, 16383));
    drive(m, rd, wr, a, 4'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad;
    for (int i = 0; i < 10000; i++) ref_mem[i] = i * 32'h9E3779B1;
    do_reset();

    // Write then read back through m0.
    issue(0, 1'b0, 1'b1, 14'h0010, 4'hF, 32'h11223344);
    issue(0, 1'b1, 1'b0, 14'h0010, 4'hF, 32'h0);
    tick();
    check_eq("t1_rdv0", smp_rdv0, 1'b1);
    check_eq("t1_rdata0", smp_rd0, 32'h11223344);
    check_eq("t1_rdv1", smp_rdv1, 1'b0);

    // Continuous contention from reset alternates m0, m1, m0, ...
    do_reset();
    drive(0, 1'b1, 1'b0, 14'h0010, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 14'h0100, 4'hF, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("alt_wait0", smp_w0, 32'(k % 2));
      check_eq("alt_wait1", smp_w1, 32'((k + 1) % 2));
      if (k > 0) check_eq("alt_rdv0", smp_rdv0, 32'(((k - 1) % 2) == 0));
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    tick();

    // Single byte lane write merges into existing word.
    issue(1, 1'b0, 1'b1, 14'h0100, 4'hF, 32'hFFFFFFFF);
    issue(1, 1'b0, 1'b1, 14'h0100, 4'h2, 32'h0000AB00);
    issue(1, 1'b1, 1'b0, 14'h0100, 4'hF, 32'h0);
    tick();
    check_eq("t3_rdata1", smp_rd1, 32'hFFFFABFF);

    // Out-of-range read, sticky error, clear, dropped out-of-range write.
    drive(0, 1'b1, 1'b0, 14'd10000, 4'hF, 32'h0);
    tick();
    check_eq("t4_cs_rd", smp_cs, 1'b0);
    check_eq("t4_wait0", smp_w0, 1'b0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    check_eq("t4_rdata0", smp_rd0, 32'hDEADBEEF);
    check_eq("t4_err_set", smp_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check_eq("t4_err_clr", smp_err, 1'b0);
    issue(1, 1'b0, 1'b1, 14'd16383, 4'hF, 32'h12345678);
    check_eq("t4_cs_wr", smp_cs, 1'b0);
    issue(0, 1'b1, 1'b0, 14'd9999, 4'hF, 32'h0);
    tick();
    check_eq("t4_edge_rdv0", smp_rdv0, 1'b1);

    // Reset lands in the return cycle of an accepted read.
    issue(0, 1'b1, 1'b0, 14'h0005, 4'hF, 32'h0);
    drive(0, 1'b1, 1'b0, 14'h0006, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 14'h0007, 4'hF, 32'h0);
    do_reset();
    tick();
    check_eq("t5_wait0", smp_w0, 1'b0);
    check_eq("t5_wait1", smp_w1, 1'b1);
    check_eq("t5_rdv0", smp_rdv0, 1'b0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    tick();

`ifdef ONCHIP_ARB_LOCK_EN
    // m1 locks for three writes; m0 stalls until the cycle after m1_lock falls.
    do_reset();
    m1_lock = 1'b1;
    drive(1, 1'b0, 1'b1, 14'h0200, 4'hF, 32'hA0A0A0A0);
    tick();
    drive(0, 1'b1, 1'b0, 14'h0020, 4'hF, 32'h0);
    for (int i = 1; i < 3; i++) begin
      drive(1, 1'b0, 1'b1, 14'(14'h0200 + i), 4'hF, 32'(i));
      tick();
      check_eq("lk_wait0", smp_w0, 1'b1);
    end
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    check_eq("lk_idle_wait0", smp_w0, 1'b1);
    m1_lock = 1'b0;
    tick();
    check_eq("lk_fall_wait0", smp_w0, 1'b1);
    tick();
    check_eq("lk_rel_wait0", smp_w0, 1'b0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (acc0 || !(m0_read || m0_write)) rand_req(0);
      if (acc1 || !(m1_read || m1_write)) rand_req(1);
      err_clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    err_clr = 1'b0;
    tick();
    tick();

    nbad = 0;
    for (int i = 0; i < 10000; i++) if (ram[i] !== ref_mem[i]) nbad++;
    check_eq("ram_sweep", nbad, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
